// File: rtl/camera_capture_engine.sv
// Camera capture engine: turns a DVP-style byte stream (VSYNC/HREF/D) into
// frame-buffer writes. Pixels are assembled from byte pairs, reformatted,
// optionally decimated 2:1 in both directions, and written with a linear
// address that saturates at the buffer depth. Frame geometry is checked and
// reported once per frame.
module camera_capture_engine #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DEPTH    = 307200,
    parameter int OUT_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    input  logic [1:0]        mode,
    input  logic              decim,
    input  logic              cont,
    input  logic              snap,
    output logic [ADDR_W-1:0] addr,
    output logic [OUT_W-1:0]  dout,
    output logic              we,
    output logic              frame_done,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic              geom_err,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [15:0]       H_CNT     = 16'(H_ACTIVE);
    localparam logic [15:0]       V_CNT     = 16'(V_ACTIVE);

    // Build a 16-bit MSB-aligned word, then keep the top OUT_W bits.
    // Mode 0 at 12 bits packs RGB565 down to RGB444; at 16 bits it is RGB565.
    // Mode 2 takes the Y byte (first of each pair) and replicates it.
    function automatic logic [OUT_W-1:0] fmt_pixel(
        input logic [1:0] fmt,
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        logic [15:0] word;
        case (fmt)
            2'd1:    word = {hi, lo};
            2'd2:    word = {hi, hi};
            default: word = (OUT_W == 16) ? {hi, lo}
                                          : {hi[7:4], hi[2:0], lo[7], lo[4:1], 4'b0000};
        endcase
        return OUT_W'(word >> (16 - OUT_W));
    endfunction

    state_t              state_q;
    state_t              state_nx;
    logic                start_frame;
    logic                end_frame;

    logic                vsync_q;
    logic                href_q;
    logic                vs_fall;
    logic                vs_rise;
    logic                href_fall;

    logic [1:0]          mode_q;
    logic                decim_q;
    logic                phase_q;
    logic [7:0]          hi_p0;
    logic [15:0]         pix_cnt_q;
    logic [15:0]         line_cnt_q;
    logic [ADDR_W-1:0]   addr_cnt_q;
    logic                full_q;
    logic                line_err_q;
    logic                byte_en;
    logic                keep_pix;

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [OUT_W-1:0]    dout_p1;
    logic                frame_done_q;
    logic [7:0]          frame_cnt_q;
    logic                geom_err_q;
    logic                ovf_q;

    assign vs_fall   = vsync_q & ~vsync;
    assign vs_rise   = ~vsync_q & vsync;
    assign href_fall = href_q & ~href;
    assign byte_en   = (state_q == ACTIVE) && href;
    assign keep_pix  = !decim_q || (!pix_cnt_q[0] && !line_cnt_q[0]);

    // Delayed copies of the sync inputs for edge detection; cleared on reset
    // so a fresh falling edge is always required after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    // Capture state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state logic plus frame start/end strobes for the datapath
    always_comb begin
        state_nx    = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cont || snap) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (vs_fall) begin
                    state_nx    = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    end_frame = 1'b1;
                    state_nx  = cont ? ARMED : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // First byte of each pixel is parked here until its partner arrives
    always_ff @(posedge clk) begin
        if (byte_en && !phase_q) begin
            hi_p0 <= d;
        end
    end

    // Byte pairing, line/pixel counting, write generation and frame status
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 2'd0;
            decim_q      <= 1'b0;
            phase_q      <= 1'b0;
            pix_cnt_q    <= 16'd0;
            line_cnt_q   <= 16'd0;
            addr_cnt_q   <= '0;
            full_q       <= 1'b0;
            line_err_q   <= 1'b0;
            vld_p1       <= 1'b0;
            addr_p1      <= '0;
            dout_p1      <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            geom_err_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            vld_p1       <= 1'b0;
            frame_done_q <= 1'b0;
            if (start_frame) begin
                mode_q     <= mode;
                decim_q    <= decim;
                phase_q    <= 1'b0;
                pix_cnt_q  <= 16'd0;
                line_cnt_q <= 16'd0;
                addr_cnt_q <= '0;
                full_q     <= 1'b0;
                line_err_q <= 1'b0;
            end else if (state_q == ACTIVE) begin
                if (end_frame) begin
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 8'd1;
                    geom_err_q   <= line_err_q || (line_cnt_q != V_CNT);
                    ovf_q        <= full_q;
                end
                if (href) begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        phase_q   <= 1'b0;
                        pix_cnt_q <= pix_cnt_q + 16'd1;
                        if (keep_pix && !full_q) begin
                            vld_p1     <= 1'b1;
                            addr_p1    <= addr_cnt_q;
                            dout_p1    <= fmt_pixel(mode_q, hi_p0, d);
                            addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
                            if (addr_cnt_q == LAST_ADDR) begin
                                full_q <= 1'b1;
                            end
                        end
                    end
                end else if (href_fall) begin
                    // A dangling first byte is dropped by forcing phase 0.
                    phase_q    <= 1'b0;
                    line_cnt_q <= line_cnt_q + 16'd1;
                    pix_cnt_q  <= 16'd0;
                    if (pix_cnt_q != H_CNT) begin
                        line_err_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign addr       = addr_p1;
    assign dout       = dout_p1;
    assign we         = vld_p1;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign frame_cnt  = frame_cnt_q;
    assign geom_err   = geom_err_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_camera_capture_engine.sv
// Directed bench for camera_capture_engine. Three instances share one
// stimulus stream: a 16-bit 4x2 engine, a 12-bit 4x4 engine and a 16-bit
// 4x2 engine with a 5-word buffer. Writes and frame_done pulses of each are
// logged on the falling clock edge and checked against hand-computed values.
module tb_camera_capture_engine;

    localparam int AW = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       vsync;
    logic       href;
    logic [7:0] d;
    logic [1:0] mode;
    logic       decim;
    logic       cont;
    logic       snap;

    logic [AW-1:0] addr16, addr12, addr5;
    logic [15:0]   dout16, dout5;
    logic [11:0]   dout12;
    logic          we16, we12, we5;
    logic          fd16, fd12, fd5;
    logic          busy16, busy12, busy5;
    logic [7:0]    fc16, fc12, fc5;
    logic          ge16, ge12, ge5;
    logic          ovf16, ovf12, ovf5;

    always #5 clk = ~clk;

    camera_capture_engine #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(AW), .DEPTH(16), .OUT_W(16)) u16 (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .d(d), .mode(mode), .decim(decim),
        .cont(cont), .snap(snap), .addr(addr16), .dout(dout16), .we(we16), .frame_done(fd16),
        .busy(busy16), .frame_cnt(fc16), .geom_err(ge16), .ovf(ovf16));

    camera_capture_engine #(.H_ACTIVE(4), .V_ACTIVE(4), .ADDR_W(AW), .DEPTH(16), .OUT_W(12)) u12 (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .d(d), .mode(mode), .decim(decim),
        .cont(cont), .snap(snap), .addr(addr12), .dout(dout12), .we(we12), .frame_done(fd12),
        .busy(busy12), .frame_cnt(fc12), .geom_err(ge12), .ovf(ovf12));

    camera_capture_engine #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(AW), .DEPTH(5), .OUT_W(16)) u5 (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .d(d), .mode(mode), .decim(decim),
        .cont(cont), .snap(snap), .addr(addr5), .dout(dout5), .we(we5), .frame_done(fd5),
        .busy(busy5), .frame_cnt(fc5), .geom_err(ge5), .ovf(ovf5));

    // Write / frame_done logs
    int            cyc = 0;
    logic [AW-1:0] wa16 [512];
    logic [15:0]   wd16 [512];
    int            wc16 [512];
    logic [AW-1:0] wa12 [512];
    logic [11:0]   wd12 [512];
    logic [AW-1:0] wa5  [512];
    logic [15:0]   wd5  [512];
    int            n16 = 0, n12 = 0, n5 = 0;
    int            nd16 = 0, nd12 = 0, nd5 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we16 && n16 < 512) begin
            wa16[n16] <= addr16;
            wd16[n16] <= dout16;
            wc16[n16] <= cyc;
            n16       <= n16 + 1;
        end
        if (we12 && n12 < 512) begin
            wa12[n12] <= addr12;
            wd12[n12] <= dout12;
            n12       <= n12 + 1;
        end
        if (we5 && n5 < 512) begin
            wa5[n5] <= addr5;
            wd5[n5] <= dout5;
            n5      <= n5 + 1;
        end
        if (fd16) nd16 <= nd16 + 1;
        if (fd12) nd12 <= nd12 + 1;
        if (fd5)  nd5  <= nd5 + 1;
    end

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [11:0] exp12;
        logic [15:0] exp16;
    } fmt_vec_t;

    fmt_vec_t    tbl [6];
    logic [11:0] dec_exp [4];

    int          checks = 0;
    int          failures = 0;
    int          t_p1;
    logic        pat_const;
    logic [7:0]  c_hi, c_lo;
    int          b16, b12, b5, bd16, bd12, bd5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pixel idx of the incrementing byte stream 0x12,0x34,0x56,... as {hi,lo}
    function automatic logic [15:0] exp_inc(input int idx);
        logic [7:0] h;
        logic [7:0] l;
        h = 8'(18 + 68 * idx);
        l = 8'(52 + 68 * idx);
        return {h, l};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        cont  = 1'b0;
        snap  = 1'b0;
        href  = 1'b0;
        vsync = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called with rst held high after at least one clock edge
    task automatic reset_check(input string tag);
        chk({tag, "_addr16"}, 32'(addr16), 0);
        chk({tag, "_dout16"}, 32'(dout16), 0);
        chk({tag, "_we16"},   32'(we16), 0);
        chk({tag, "_fd16"},   32'(fd16), 0);
        chk({tag, "_busy16"}, 32'(busy16), 0);
        chk({tag, "_fc16"},   32'(fc16), 0);
        chk({tag, "_ge16"},   32'(ge16), 0);
        chk({tag, "_ovf16"},  32'(ovf16), 0);
        chk({tag, "_addr12"}, 32'(addr12), 0);
        chk({tag, "_dout12"}, 32'(dout12), 0);
        chk({tag, "_we12"},   32'(we12), 0);
        chk({tag, "_fd12"},   32'(fd12), 0);
        chk({tag, "_busy12"}, 32'(busy12), 0);
        chk({tag, "_fc12"},   32'(fc12), 0);
        chk({tag, "_ge12"},   32'(ge12), 0);
        chk({tag, "_ovf12"},  32'(ovf12), 0);
        chk({tag, "_addr5"},  32'(addr5), 0);
        chk({tag, "_dout5"},  32'(dout5), 0);
        chk({tag, "_we5"},    32'(we5), 0);
        chk({tag, "_fd5"},    32'(fd5), 0);
        chk({tag, "_busy5"},  32'(busy5), 0);
        chk({tag, "_fc5"},    32'(fc5), 0);
        chk({tag, "_ge5"},    32'(ge5), 0);
        chk({tag, "_ovf5"},   32'(ovf5), 0);
    endtask

    // Action injected in the blanking gap after the first line:
    // 1 snap pulse, 2 drop cont, 3 reset pulse
    task automatic mid_action(input int mid);
        case (mid)
            1: begin
                @(negedge clk); snap = 1'b1;
                @(negedge clk); snap = 1'b0;
            end
            2: cont = 1'b0;
            3: begin
                @(negedge clk); rst = 1'b1;
                @(negedge clk);
                chk("G_we_in_rst", 32'(we16), 0);
                chk("G_fd_in_rst", 32'(fd16), 0);
                rst = 1'b0;
            end
            default: ;
        endcase
    endtask

    // One frame: line 0 carries nb0 bytes, the others nbr. vsync is left high.
    task automatic send_frame_b(input int nl, input int nb0, input int nbr, input int mid);
        int k;
        int nb;
        k = 0;
        @(negedge clk); vsync = 1'b1; href = 1'b0;
        step(1);
        @(negedge clk); vsync = 1'b0;
        step(2);
        for (int l = 0; l < nl; l++) begin
            nb = (l == 0) ? nb0 : nbr;
            for (int b = 0; b < nb; b++) begin
                @(negedge clk);
                href = 1'b1;
                if (pat_const) d = (k % 2 == 0) ? c_hi : c_lo;
                else           d = 8'(18 + 34 * k);
                if (k == 1) t_p1 = cyc + 1;
                k++;
            end
            @(negedge clk); href = 1'b0;
            if (l == 0) mid_action(mid);
            step(2);
        end
        @(negedge clk); vsync = 1'b1;
        step(4);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; href = 1'b0; d = 8'h00; mode = 2'd0;
        decim = 1'b0; cont = 1'b0; snap = 1'b0;
        pat_const = 1'b0; c_hi = 8'h00; c_lo = 8'h00; t_p1 = 0;

        tbl[0] = '{mode: 2'd0, hi: 8'hF8, lo: 8'h1F, exp12: 12'hF0F, exp16: 16'hF81F};
        tbl[1] = '{mode: 2'd1, hi: 8'hF8, lo: 8'h1F, exp12: 12'hF81, exp16: 16'hF81F};
        tbl[2] = '{mode: 2'd2, hi: 8'hA5, lo: 8'h3C, exp12: 12'hA5A, exp16: 16'hA5A5};
        tbl[3] = '{mode: 2'd3, hi: 8'hF8, lo: 8'h1F, exp12: 12'hF0F, exp16: 16'hF81F};
        tbl[4] = '{mode: 2'd0, hi: 8'h12, lo: 8'h34, exp12: 12'h14A, exp16: 16'h1234};
        tbl[5] = '{mode: 2'd1, hi: 8'h12, lo: 8'h34, exp12: 12'h123, exp16: 16'h1234};
        dec_exp[0] = 12'h123;
        dec_exp[1] = 12'h9AB;
        dec_exp[2] = 12'h325;
        dec_exp[3] = 12'hBAD;

        // Reset values
        step(3);
        reset_check("R0");
        rst = 1'b0;

        // Continuous 4x2 passthrough, plus 5-word overflow on u5
        b16 = n16; b5 = n5; bd16 = nd16; bd5 = nd5;
        mode = 2'd1; decim = 1'b0; cont = 1'b1; pat_const = 1'b0;
        send_frame_b(2, 8, 8, 0);
        chk("B_nwr", n16 - b16, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("B_addr%0d", i), 32'(wa16[b16 + i]), i);
            chk($sformatf("B_dout%0d", i), 32'(wd16[b16 + i]), 32'(exp_inc(i)));
        end
        chk("B_first", 32'(wd16[b16]), 32'h1234);
        chk("B_latency", wc16[b16], t_p1);
        chk("B_done", nd16 - bd16, 1);
        chk("B_cnt", 32'(fc16), 1);
        chk("B_geom", 32'(ge16), 0);
        chk("B_ovf", 32'(ovf16), 0);
        chk("O_nwr", n5 - b5, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("O_addr%0d", i), 32'(wa5[b5 + i]), i);
            chk($sformatf("O_dout%0d", i), 32'(wd5[b5 + i]), 32'(exp_inc(i)));
        end
        chk("O_done", nd5 - bd5, 1);
        chk("O_ovf", 32'(ovf5), 1);
        chk("O_geom", 32'(ge5), 0);

        // Reset clears counters and status
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        reset_check("R1");
        rst = 1'b0;

        // Pixel formatting table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            b16 = n16; b12 = n12;
            mode = tbl[i].mode; decim = 1'b0; cont = 1'b1;
            pat_const = 1'b1; c_hi = tbl[i].hi; c_lo = tbl[i].lo;
            send_frame_b(2, 8, 8, 0);
            chk($sformatf("T%0d_dout12", i), 32'(wd12[b12]), 32'(tbl[i].exp12));
            chk($sformatf("T%0d_dout16", i), 32'(wd16[b16]), 32'(tbl[i].exp16));
            chk($sformatf("T%0d_nwr16", i), n16 - b16, 8);
            chk($sformatf("T%0d_geom16", i), 32'(ge16), 0);
        end
        pat_const = 1'b0;

        // 2:1 decimation on the 4x4 engine
        do_reset();
        b12 = n12; bd12 = nd12;
        mode = 2'd1; decim = 1'b1; cont = 1'b1;
        send_frame_b(4, 8, 8, 0);
        chk("C_nwr", n12 - b12, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("C_addr%0d", i), 32'(wa12[b12 + i]), i);
            chk($sformatf("C_dout%0d", i), 32'(wd12[b12 + i]), 32'(dec_exp[i]));
        end
        chk("C_done", nd12 - bd12, 1);
        chk("C_geom", 32'(ge12), 0);
        decim = 1'b0;

        // Geometry checks and partial-byte discard
        do_reset();
        mode = 2'd1; cont = 1'b1;
        send_frame_b(3, 8, 8, 0);
        chk("D_3lines_geom", 32'(ge16), 1);
        send_frame_b(2, 8, 8, 0);
        chk("D_good_geom", 32'(ge16), 0);
        send_frame_b(2, 6, 8, 0);
        chk("D_3pix_geom", 32'(ge16), 1);
        step(5);
        chk("D_geom_hold", 32'(ge16), 1);
        b16 = n16;
        send_frame_b(2, 9, 8, 0);
        chk("D_odd_geom", 32'(ge16), 0);
        chk("D_odd_nwr", n16 - b16, 8);
        chk("D_odd_realign", 32'(wd16[b16 + 4]), 32'h4466);

        // Single-shot: snap arms one frame, snap while busy is ignored
        do_reset();
        b16 = n16; bd16 = nd16;
        mode = 2'd1; snap = 1'b1;
        @(negedge clk); snap = 1'b0;
        chk("E_busy_armed", 32'(busy16), 1);
        send_frame_b(2, 8, 8, 1);
        send_frame_b(2, 8, 8, 0);
        chk("E_nwr", n16 - b16, 8);
        chk("E_done", nd16 - bd16, 1);
        chk("E_busy", 32'(busy16), 0);
        chk("E_cnt", 32'(fc16), 1);

        // cont dropped mid-frame: frame completes, then idle
        do_reset();
        b16 = n16; bd16 = nd16;
        mode = 2'd1; cont = 1'b1;
        send_frame_b(2, 8, 8, 2);
        chk("F_nwr", n16 - b16, 8);
        chk("F_done", nd16 - bd16, 1);
        chk("F_busy", 32'(busy16), 0);
        send_frame_b(2, 8, 8, 0);
        chk("F_nwr_after", n16 - b16, 8);
        chk("F_done_after", nd16 - bd16, 1);

        // Reset mid-frame aborts; capture resumes on the next frame
        do_reset();
        b16 = n16; bd16 = nd16;
        mode = 2'd1; cont = 1'b1;
        send_frame_b(2, 8, 8, 3);
        chk("G_nwr", n16 - b16, 4);
        chk("G_done", nd16 - bd16, 0);
        chk("G_cnt", 32'(fc16), 0);
        send_frame_b(2, 8, 8, 0);
        chk("G_nwr_next", n16 - b16, 12);
        chk("G_addr_restart", 32'(wa16[b16 + 4]), 0);
        chk("G_done_next", nd16 - bd16, 1);
        chk("G_cnt_next", 32'(fc16), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
